// File: rtl/tt_willow_pkg.sv
// Shared constants for the willow tile: command opcodes,
// display select codes and the fixed bidir output-enable mask.
package tt_willow_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_DUTY  = 3'd2;
  localparam logic [2:0] OP_PRESC = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_CTRL  = 3'd6;
  localparam logic [2:0] OP_CLR   = 3'd7;

  localparam logic [1:0] SEL_CNT   = 2'd0;
  localparam logic [1:0] SEL_DUTY  = 2'd1;
  localparam logic [1:0] SEL_PRESC = 2'd2;
  localparam logic [1:0] SEL_ACC   = 2'd3;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/willow_tick_counter.sv
// Prescaled 8-bit counter with load/clear and a one-cycle wrap pulse.
// Ports: clk, rst, en, run, presc, load, clear, load_val -> cnt, wrap.
module willow_tick_counter
  import tt_willow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       run,
  input  logic [7:0] presc,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] load_val,
  output logic [7:0] cnt,
  output logic       wrap
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pdiv_q, pdiv_d;
  logic       wrap_q, wrap_d;

  // Commands take priority over a tick; wrap only fires on FF->00.
  always_comb begin
    cnt_d  = cnt_q;
    pdiv_d = pdiv_q;
    wrap_d = 1'b0;
    if (en) begin
      if (clear) begin
        cnt_d  = 8'h00;
        pdiv_d = 8'h00;
      end else if (load) begin
        cnt_d  = load_val;
        pdiv_d = 8'h00;
      end else if (run) begin
        if (pdiv_q == presc) begin
          pdiv_d = 8'h00;
          cnt_d  = cnt_q + 8'h01;
          wrap_d = (cnt_q == 8'hFF);
        end else begin
          pdiv_d = pdiv_q + 8'h01;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'h00;
      pdiv_q <= 8'h00;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pdiv_q <= pdiv_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/tt_um_willow240_test.sv
// Willow tile top: strobe-edge command decode, duty/acc/ctrl regs, PWM and muxes.
// Ports: TinyTapeout harness pinout (ui_in data, uio_in cmd, uo_out view, uio_out status).
module tt_um_willow240_test
  import tt_willow_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Harness name kept, but this reset is active-high.
  logic rst;
  assign rst = rst_n;

  logic       strb_q, strb_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       run_q, run_d;
  logic [1:0] sel_q, sel_d;

  logic [2:0] op;
  logic       fire;
  logic       ld;
  logic       clr;
  logic [8:0] sum;
  logic [7:0] cnt;
  logic       wrap;
  logic       pwm;
  logic       unused_ok;

  assign unused_ok = ^uio_in[7:4];

  assign op   = uio_in[2:0];
  assign fire = ena & uio_in[3] & ~strb_q;
  assign ld   = fire & (op == OP_LOAD);
  assign clr  = fire & (op == OP_CLR);
  assign sum  = {1'b0, acc_q} + {1'b0, ui_in};

  always_comb begin
    strb_d  = ena ? uio_in[3] : strb_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    run_d   = run_q;
    sel_d   = sel_q;
    if (fire) begin
      unique case (op)
        OP_DUTY:  duty_d = ui_in;
        OP_PRESC: presc_d = ui_in;
        OP_ADD: begin
          acc_d   = sum[7:0];
          carry_d = sum[8];
        end
        OP_XOR: begin
          acc_d   = acc_q ^ ui_in;
          carry_d = 1'b0;
        end
        OP_CTRL: begin
          run_d = ui_in[0];
          sel_d = ui_in[2:1];
        end
        OP_CLR: begin
          acc_d   = 8'h00;
          carry_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Strobe flop resets high so a strobe held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q  <= 1'b1;
      duty_q  <= 8'h00;
      presc_q <= 8'h00;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
      run_q   <= 1'b0;
      sel_q   <= SEL_CNT;
    end else begin
      strb_q  <= strb_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      run_q   <= run_d;
      sel_q   <= sel_d;
    end
  end

  willow_tick_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (ena),
    .run      (run_q),
    .presc    (presc_q),
    .load     (ld),
    .clear    (clr),
    .load_val (ui_in),
    .cnt      (cnt),
    .wrap     (wrap)
  );

  assign pwm = (cnt < duty_q);

  always_comb begin
    uo_out = cnt;
    unique case (sel_q)
      SEL_CNT:   uo_out = cnt;
      SEL_DUTY:  uo_out = duty_q;
      SEL_PRESC: uo_out = presc_q;
      SEL_ACC:   uo_out = acc_q;
      default:   uo_out = cnt;
    endcase
  end

  assign uio_out = {run_q, carry_q, wrap, pwm, 4'h0};
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_willow240_test.sv
// Directed-vector bench for the willow tile.
// Drives commands #1 after posedge and samples outputs at the same point.
module tb_tt_um_willow240_test;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt_um_willow240_test dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] d);
    ui_in  = d;
    uio_in = {4'h0, 1'b1, op};
    step();
    uio_in = 8'h00;
    step();
  endtask

  function automatic logic [7:0] b(input logic v);
    return {7'b0, v};
  endfunction

  initial begin
    logic [7:0] e;
    int highs;

    // reset with a LOAD strobe held high through release
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h55;
    uio_in = 8'h09;
    step(2);
    chk("oe_in_reset", uio_oe, 8'hF0);
    rst_n = 1'b0;
    step(2);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hF0);
    uio_in = 8'h00;
    step();
    chk("no_cmd_rel", uo_out, 8'h00);

    // LOAD FE, presc 0, run -> FE FF 00 01
    cmd(3'd1, 8'hFE);
    chk("load_fe", uo_out, 8'hFE);
    cmd(3'd3, 8'h00);
    ui_in  = 8'h01;
    uio_in = 8'h0E;
    step();
    chk("run_fe", uo_out, 8'hFE);
    uio_in = 8'h00;
    step();
    chk("run_ff", uo_out, 8'hFF);
    chk("wrap_ff", b(uio_out[5]), 8'h00);
    step();
    chk("run_00", uo_out, 8'h00);
    chk("wrap_00", b(uio_out[5]), 8'h01);
    step();
    chk("run_01", uo_out, 8'h01);
    chk("wrap_01", b(uio_out[5]), 8'h00);
    cmd(3'd6, 8'h00);
    chk("stop_hold", uo_out, 8'h02);

    // presc 3 -> one increment per 4 cycles
    cmd(3'd1, 8'h00);
    cmd(3'd3, 8'h03);
    ui_in  = 8'h01;
    uio_in = 8'h0E;
    step();
    uio_in = 8'h00;
    step(3);
    chk("p3_c3", uo_out, 8'h00);
    step();
    chk("p3_c4", uo_out, 8'h01);
    step(4);
    chk("p3_c8", uo_out, 8'h02);
    ui_in  = 8'h00;
    uio_in = 8'h0E;
    step();
    uio_in = 8'h00;
    step(10);
    chk("p3_hold", uo_out, 8'h02);
    chk("run_off", b(uio_out[7]), 8'h00);
    cmd(3'd6, 8'h04);
    chk("sel_presc", uo_out, 8'h03);

    // accumulator
    cmd(3'd6, 8'h06);
    cmd(3'd4, 8'hF0);
    chk("acc_f0", uo_out, 8'hF0);
    cmd(3'd4, 8'h20);
    chk("acc_sum", uo_out, 8'h10);
    chk("carry1", b(uio_out[6]), 8'h01);
    cmd(3'd5, 8'hFF);
    chk("acc_xor", uo_out, 8'hEF);
    chk("carry0", b(uio_out[6]), 8'h00);
    cmd(3'd7, 8'h00);
    chk("clr_acc", uo_out, 8'h00);
    cmd(3'd6, 8'h02);
    chk("clr_duty_kept", uo_out, 8'h00);
    cmd(3'd6, 8'h00);
    chk("clr_cnt", uo_out, 8'h00);

    // PWM sweep, duty 0x40
    cmd(3'd2, 8'h40);
    cmd(3'd3, 8'h00);
    ui_in  = 8'h01;
    uio_in = 8'h0E;
    step();
    uio_in = 8'h00;
    e = 8'h00;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      chk("sweep_cnt", uo_out, e);
      chk("sweep_pwm", b(uio_out[4]), b(e < 8'h40));
      if (uio_out[4]) highs++;
      step();
      e = e + 8'h01;
    end
    chk("pwm_highs", 8'(highs), 8'd64);

    // ena=0 freezes everything, strobes ignored
    ena   = 1'b0;
    ui_in = 8'hAA;
    for (int k = 0; k < 6; k++) begin
      uio_in = k[0] ? 8'h00 : 8'h09;
      step();
    end
    uio_in = 8'h00;
    chk("ena0_cnt", uo_out, e);
    chk("ena0_wrap", b(uio_out[5]), 8'h00);
    chk("ena0_run", b(uio_out[7]), 8'h01);
    ena = 1'b1;
    step();
    chk("ena1_cnt", uo_out, e + 8'h01);

    // LOAD beats a tick, no wrap on loaded FF
    ui_in  = 8'hFF;
    uio_in = 8'h09;
    step();
    chk("ld_ff", uo_out, 8'hFF);
    uio_in = 8'h00;
    step();
    chk("tick_00", uo_out, 8'h00);
    chk("tick_wrap", b(uio_out[5]), 8'h01);
    ui_in  = 8'hFE;
    uio_in = 8'h09;
    step();
    uio_in = 8'h00;
    step();
    chk("pre_ff", uo_out, 8'hFF);
    ui_in  = 8'h30;
    uio_in = 8'h09;
    step();
    chk("ld_wins", uo_out, 8'h30);
    chk("ld_nowrap", b(uio_out[5]), 8'h00);
    uio_in = 8'h00;
    step();

    // held strobe executes once
    cmd(3'd6, 8'h06);
    ui_in  = 8'h05;
    uio_in = 8'h0C;
    step(5);
    chk("held_once", uo_out, 8'h05);
    uio_in = 8'h00;
    step();
    chk("held_after", uo_out, 8'h05);

    // duty boundaries
    cmd(3'd2, 8'hFF);
    cmd(3'd1, 8'hFE);
    chk("dff_fe", b(uio_out[4]), 8'h01);
    cmd(3'd1, 8'hFF);
    chk("dff_ff", b(uio_out[4]), 8'h00);
    cmd(3'd2, 8'h00);
    cmd(3'd1, 8'h00);
    chk("d00_00", b(uio_out[4]), 8'h00);

    // reset mid-operation overrides command and tick
    cmd(3'd6, 8'h01);
    ui_in  = 8'h77;
    uio_in = 8'h09;
    rst_n  = 1'b1;
    step();
    chk("mrst_uo", uo_out, 8'h00);
    chk("mrst_uio", uio_out, 8'h00);
    chk("mrst_oe", uio_oe, 8'hF0);
    rst_n = 1'b0;
    step();
    chk("mrst_rel", uo_out, 8'h00);
    uio_in = 8'h00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
